// File: rtl/image_stream_reader_if.sv
// Frame-buffer read port plus outgoing pixel stream, bundled for the raster reader.
interface image_stream_reader_if #(
    parameter int ADDR_W = 16
);
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        rd_data;
    logic              pix_valid;
    logic              pix_ready;
    logic [7:0]        pix_data;
    logic              pix_last;

    modport master (
        output rd_en, rd_addr, pix_valid, pix_data, pix_last,
        input  rd_data, pix_ready
    );

    modport slave (
        input  rd_en, rd_addr, pix_valid, pix_data, pix_last,
        output rd_data, pix_ready
    );
endinterface

// File: rtl/image_stream_reader.sv
// Raster-order frame reader: issues credit-limited RAM reads, absorbs the 2-cycle
// read latency in a small show-ahead FIFO and streams pixels with a last marker.
module image_stream_reader #(
    parameter int IMG_W      = 256,
    parameter int IMG_H      = 256,
    parameter int ADDR_W     = $clog2(IMG_W*IMG_H),
    parameter int FIFO_DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic busy,
    output logic done,
    image_stream_reader_if.master bus
);

    // state  | meaning
    // S_IDLE | waiting for start, nothing outstanding
    // S_READ | issuing reads, collecting return data, streaming pixels
    // S_DONE | one-cycle completion pulse
    typedef enum logic [1:0] {S_IDLE, S_READ, S_DONE} state_t;

    localparam int TOTAL = IMG_W * IMG_H;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [ADDR_W:0]  TOTAL_C = (ADDR_W+1)'(TOTAL);
    localparam logic [ADDR_W:0]  LAST_C  = (ADDR_W+1)'(TOTAL - 1);
    localparam logic [CNT_W:0]   DEPTH_C = (CNT_W+1)'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] FULL_C  = CNT_W'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0] PTR_MAX = PTR_W'(FIFO_DEPTH - 1);

    state_t            state_q, state_d;
    logic [ADDR_W:0]   issue_addr_q, issue_addr_d;
    logic [ADDR_W:0]   pix_cnt_q, pix_cnt_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              v1_q, v2_q;
    logic [7:0]        mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic              rd_en_w;
    logic              push, pop, fifo_empty;
    logic [CNT_W:0]    credit;

    assign fifo_empty = (count_q == '0);
    assign push       = v2_q;
    assign pop        = !fifo_empty && bus.pix_ready;
    assign credit     = {1'b0, count_q} + {{CNT_W{1'b0}}, v1_q} + {{CNT_W{1'b0}}, v2_q};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_READ;
            S_READ:  if (pop && (pix_cnt_q == LAST_C)) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy    = (state_q != S_IDLE);
        done    = (state_q == S_DONE);
        rd_en_w = (state_q == S_READ) && (issue_addr_q < TOTAL_C) && (credit < DEPTH_C);
    end

    always_comb begin
        issue_addr_d = issue_addr_q;
        pix_cnt_d    = pix_cnt_q;
        rd_addr_d    = rd_addr_q;
        if (state_q == S_IDLE && start) begin
            issue_addr_d = '0;
            pix_cnt_d    = '0;
        end else begin
            if (rd_en_w) begin
                issue_addr_d = issue_addr_q + 1'b1;
                rd_addr_d    = issue_addr_q[ADDR_W-1:0];
            end
            if (pop) pix_cnt_d = pix_cnt_q + 1'b1;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = (wr_ptr_q == PTR_MAX) ? '0 : wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = (rd_ptr_q == PTR_MAX) ? '0 : rd_ptr_q + 1'b1;
        if (push && !pop)      count_d = count_q + 1'b1;
        else if (pop && !push) count_d = count_q - 1'b1;
    end

    // Clearing v1/v2 on reset is what drops any read data still returning from the RAM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issue_addr_q <= '0;
            pix_cnt_q    <= '0;
            rd_addr_q    <= '0;
            v1_q         <= 1'b0;
            v2_q         <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
        end else begin
            issue_addr_q <= issue_addr_d;
            pix_cnt_q    <= pix_cnt_d;
            rd_addr_q    <= rd_addr_d;
            v1_q         <= rd_en_w;
            v2_q         <= v1_q;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= bus.rd_data;
    end

    assign bus.rd_en     = rd_en_w;
    assign bus.rd_addr   = rd_en_w ? issue_addr_q[ADDR_W-1:0] : rd_addr_q;
    assign bus.pix_valid = !fifo_empty;
    assign bus.pix_data  = fifo_empty ? 8'h00 : mem_q[rd_ptr_q];
    assign bus.pix_last  = !fifo_empty && (pix_cnt_q == LAST_C);

    // The issue credit makes this unreachable; a hit means the credit logic is broken.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && count_q == FULL_C));

endmodule

// File: tb/tb_image_stream_reader.sv
// Randomized bench for image_stream_reader: a frame-level reference model checks every
// cycle, and directed phases pin latency, backpressure, restart and reset behaviour.
module tb_image_stream_reader;
    localparam int W     = 16;
    localparam int H     = 16;
    localparam int N     = W * H;
    localparam int AW    = $clog2(N);
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic busy;
    logic done;

    image_stream_reader_if #(.ADDR_W(AW)) bus ();

    image_stream_reader #(
        .IMG_W(W), .IMG_H(H), .ADDR_W(AW), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .bus(bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] ram_val(input int a);
        return 8'(a) ^ 8'hA5;
    endfunction

    // RAM with 2-cycle latency; junk on the data bus whenever no read is returning.
    logic [7:0] d1   = 8'h00;
    logic       d1_v = 1'b0;
    always @(posedge clk) begin
        d1_v        <= bus.rd_en;
        d1          <= bus.rd_en ? ram_val(int'(bus.rd_addr)) : 8'h00;
        bus.rd_data <= d1_v ? d1 : 8'($urandom);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Frame-level reference model, advanced once per cycle at the falling edge.
    bit         m_active    = 0;
    bit         m_done_next = 0;
    int         m_issued    = 0;
    int         m_accepted  = 0;
    int         m_last_addr = 0;
    bit         prev_valid  = 0;
    bit         prev_ready  = 0;
    logic [7:0] prev_data   = 8'h00;
    logic       prev_last   = 1'b0;
    int         rden_cnt    = 0;
    int         run         = 0;
    int         max_run     = 0;
    int         done_cnt    = 0;
    int         start_cyc   = 0;
    int         first_valid_cyc = -1;
    int         done_cyc    = 0;
    int         last_data   = 0;

    always @(negedge clk) begin
        bit hs;
        bit done_now;
        if (rst) begin
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_rd_en", bus.rd_en, 0);
            chk("rst_rd_addr", bus.rd_addr, 0);
            chk("rst_pix_valid", bus.pix_valid, 0);
            chk("rst_pix_data", bus.pix_data, 0);
            chk("rst_pix_last", bus.pix_last, 0);
            m_active = 0; m_done_next = 0; m_issued = 0; m_accepted = 0;
            m_last_addr = 0; prev_valid = 0; run = 0;
        end else begin
            chk("busy", busy, m_active);
            chk("done", done, m_done_next);
            if (bus.rd_en) begin
                chk("rden_in_frame", m_active, 1);
                chk("rd_addr", bus.rd_addr, m_issued);
                chk("rden_range", m_issued < N, 1);
                chk("rden_credit", (m_issued - m_accepted) < DEPTH, 1);
                m_last_addr = m_issued;
                m_issued++;
                rden_cnt++;
                run++;
                if (run > max_run) max_run = run;
            end else begin
                chk("rd_addr_hold", bus.rd_addr, m_last_addr);
                run = 0;
            end
            if (prev_valid && !prev_ready) begin
                chk("stall_valid", bus.pix_valid, 1);
                chk("stall_data", bus.pix_data, prev_data);
                chk("stall_last", bus.pix_last, prev_last);
            end
            if (bus.pix_valid) begin
                chk("valid_in_frame", m_active, 1);
                chk("pix_data", bus.pix_data, ram_val(m_accepted));
                chk("pix_last", bus.pix_last, m_accepted == N - 1);
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
                if (bus.pix_last) last_data = int'(bus.pix_data);
            end
            hs = bus.pix_valid && bus.pix_ready;
            if (hs) m_accepted++;
            prev_valid = bus.pix_valid;
            prev_ready = bus.pix_ready;
            prev_data  = bus.pix_data;
            prev_last  = bus.pix_last;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            done_now    = m_done_next;
            m_done_next = hs && (m_accepted == N);
            if (done_now) begin
                m_active = 0;
            end else if (!m_active && start) begin
                m_active = 1; m_issued = 0; m_accepted = 0;
                rden_cnt = 0; max_run = 0; first_valid_cyc = -1;
                start_cyc = cyc; last_data = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string nm, input int bound, input bit rnd);
        int  d0;
        bit  seen;
        d0   = done_cnt;
        seen = 0;
        for (int i = 0; i < bound && !seen; i++) begin
            tick();
            if (done_cnt != d0) seen = 1;
            else if (rnd) bus.pix_ready = 1'($urandom_range(0, 1));
        end
        if (!seen) chk({nm, "_done_timeout"}, 0, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        bit reached;
        rst = 1'b1;
        start = 1'b0;
        bus.pix_ready = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // full-rate frame
        bus.pix_ready = 1'b1;
        d0 = done_cnt;
        pulse_start();
        wait_done("t1", 600, 0);
        chk("t1_first_latency", first_valid_cyc - start_cyc, 4);
        chk("t1_frame_time", done_cyc - start_cyc, N + 4);
        chk("t1_rden_count", rden_cnt, N);
        chk("t1_rden_run", max_run, N);
        chk("t1_last_pixel", last_data, 32'h5A);
        chk("t1_done_count", done_cnt - d0, 1);
        @(negedge clk);
        chk("t1_busy_after", busy, 0);

        // stalled start
        tick();
        bus.pix_ready = 1'b0;
        d0 = done_cnt;
        pulse_start();
        repeat (9) tick();
        chk("t2_rden_stall", rden_cnt, 4);
        chk("t2_valid_stall", bus.pix_valid, 1);
        chk("t2_data_stall", bus.pix_data, 32'hA5);
        bus.pix_ready = 1'b1;
        wait_done("t2", 600, 0);
        chk("t2_rden_count", rden_cnt, N);
        chk("t2_done_count", done_cnt - d0, 1);

        // random backpressure
        d0 = done_cnt;
        bus.pix_ready = 1'($urandom_range(0, 1));
        pulse_start();
        wait_done("t3", 3000, 1);
        chk("t3_rden_count", rden_cnt, N);
        chk("t3_done_count", done_cnt - d0, 1);

        // start re-pulsed mid-frame is ignored
        d0 = done_cnt;
        pulse_start();
        for (int i = 0; i < 50; i++) begin
            bus.pix_ready = 1'($urandom_range(0, 1));
            tick();
        end
        pulse_start();
        wait_done("t4", 3000, 1);
        chk("t4_rden_count", rden_cnt, N);
        repeat (5) tick();
        chk("t4_single_frame", done_cnt - d0, 1);
        chk("t4_idle_busy", busy, 0);
        d0 = done_cnt;
        bus.pix_ready = 1'b1;
        pulse_start();
        wait_done("t4b", 600, 0);
        chk("t4b_first_latency", first_valid_cyc - start_cyc, 4);
        chk("t4b_done_count", done_cnt - d0, 1);

        // reset mid-frame, with start held during reset
        tick();
        d0 = done_cnt;
        bus.pix_ready = 1'b1;
        pulse_start();
        reached = 0;
        for (int i = 0; i < 100 && !reached; i++) begin
            tick();
            if (m_accepted >= 5) reached = 1;
        end
        if (!reached) chk("t5_reach_5_pixels", 0, 1);
        chk("t5_inflight_at_rst", m_issued - m_accepted - (bus.pix_valid ? 1 : 0), 2);
        rst   = 1'b1;
        start = 1'b1;
        #1;
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_rd_en", bus.rd_en, 0);
        chk("t5_rst_rd_addr", bus.rd_addr, 0);
        chk("t5_rst_pix_valid", bus.pix_valid, 0);
        chk("t5_rst_pix_data", bus.pix_data, 0);
        chk("t5_rst_pix_last", bus.pix_last, 0);
        repeat (2) tick();
        start = 1'b0;
        tick();
        rst = 1'b0;
        repeat (6) tick();
        chk("t5_busy_after_rst", busy, 0);
        chk("t5_no_done", done_cnt - d0, 0);
        pulse_start();
        wait_done("t5", 600, 0);
        chk("t5_rden_count", rden_cnt, N);
        chk("t5_last_pixel", last_data, 32'h5A);
        chk("t5_done_count", done_cnt - d0, 1);

        repeat (3) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
